itlb_ptw: RTL and testbench



---
 rtl/itlb_ptw.sv | 181 ++++++++++++++++++
 tb/tb_itlb_ptw.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itlb_ptw.sv
`default_nettype none
// ------------------------------------------------------------------------
// itlb_ptw: Sv32 two-level page-table walker serving ITLB misses. rev 1.0
// ------------------------------------------------------------------------
module itlb_ptw #(
  parameter int VADDR_WD = 32,
  parameter int PADDR_WD = 34,
  parameter int MXLEN    = 32,
  parameter int ASID_WD  = 9
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic [MXLEN-1:0]    satp_i,
  input  logic                miss_valid_i,
  output logic                miss_ready_o,
  input  logic [VADDR_WD-1:0] miss_vaddr_i,
  input  logic [ASID_WD-1:0]  miss_asid_i,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [PADDR_WD-1:0] mem_req_addr_o,
  input  logic                mem_resp_valid_i,
  input  logic [MXLEN-1:0]    mem_resp_data_i,
  input  logic                mem_resp_err_i,
  output logic                refill_valid_o,
  output logic [19:0]         refill_vpn_o,
  output logic [ASID_WD-1:0]  refill_asid_o,
  output logic [MXLEN-1:0]    refill_pte_o,
  output logic                refill_super_o,
  output logic                fault_valid_o,
  output logic                fault_access_o,
  output logic                busy_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    L1_REQ  = 3'd1,
    L1_WAIT = 3'd2,
    L0_REQ  = 3'd3,
    L0_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [19:0]           vpn_q, vpn_d;
  logic [ASID_WD-1:0]    asid_q, asid_d;
  logic [PADDR_WD-1:0]   addr_q, addr_d;
  logic [MXLEN-1:0]      pte_q, pte_d;
  logic                  super_q, super_d;
  logic                  fault_q, fault_d;
  logic                  access_q, access_d;
  logic                  kill_q, kill_d;

  logic                  is_l1, kill_now, pte_v, pte_r, pte_w, pte_x, pte_a;
  logic [PADDR_WD-1:0]   l1_addr, l0_addr;
  logic                  unused_bits;

  assign unused_bits = ^{miss_vaddr_i[11:0], satp_i[30:22]};

  assign is_l1    = (state_q == L1_WAIT);
  assign kill_now = kill_q | flush_i;
  assign pte_v    = mem_resp_data_i[0];
  assign pte_r    = mem_resp_data_i[1];
  assign pte_w    = mem_resp_data_i[2];
  assign pte_x    = mem_resp_data_i[3];
  assign pte_a    = mem_resp_data_i[6];

  assign l1_addr = PADDR_WD'({satp_i[21:0], 12'h000})
                 + PADDR_WD'({miss_vaddr_i[31:22], 2'b00});
  assign l0_addr = PADDR_WD'({mem_resp_data_i[31:10], 12'h000})
                 + PADDR_WD'({vpn_q[9:0], 2'b00});

  always_comb begin
    state_d  = state_q;
    vpn_d    = vpn_q;
    asid_d   = asid_q;
    addr_d   = addr_q;
    pte_d    = pte_q;
    super_d  = super_q;
    fault_d  = fault_q;
    access_d = access_q;
    kill_d   = kill_q;
    case (state_q)
      IDLE: begin
        if (miss_valid_i && !flush_i) begin
          vpn_d    = miss_vaddr_i[31:12];
          asid_d   = miss_asid_i;
          kill_d   = 1'b0;
          fault_d  = 1'b0;
          access_d = 1'b0;
          super_d  = 1'b0;
          if (!satp_i[31]) begin
            pte_d   = {2'b00, miss_vaddr_i[31:12], 10'h0CB};
            state_d = DONE;
          end else begin
            addr_d  = l1_addr;
            state_d = L1_REQ;
          end
        end
      end
      L1_REQ, L0_REQ: begin
        kill_d = kill_now;
        if (mem_req_ready_i) state_d = (state_q == L1_REQ) ? L1_WAIT : L0_WAIT;
      end
      L1_WAIT, L0_WAIT: begin
        kill_d = kill_now;
        if (mem_resp_valid_i) begin
          state_d = DONE;
          if (kill_now) begin
            state_d = IDLE;
          end else if (mem_resp_err_i) begin
            fault_d  = 1'b1;
            access_d = 1'b1;
          end else if (!pte_v || (!pte_r && pte_w)) begin
            fault_d = 1'b1;
          end else if (!pte_r && !pte_x) begin
            // Pointer PTE: only legal at level 1
            if (is_l1) begin
              addr_d  = l0_addr;
              state_d = L0_REQ;
            end else begin
              fault_d = 1'b1;
            end
          end else if ((is_l1 && (mem_resp_data_i[19:10] != 10'd0)) || !pte_x || !pte_a) begin
            fault_d = 1'b1;
          end else begin
            pte_d   = mem_resp_data_i;
            super_d = is_l1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      vpn_q    <= '0;
      asid_q   <= '0;
      addr_q   <= '0;
      pte_q    <= '0;
      super_q  <= 1'b0;
      fault_q  <= 1'b0;
      access_q <= 1'b0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vpn_q    <= vpn_d;
      asid_q   <= asid_d;
      addr_q   <= addr_d;
      pte_q    <= pte_d;
      super_q  <= super_d;
      fault_q  <= fault_d;
      access_q <= access_d;
      kill_q   <= kill_d;
    end
  end

  logic in_done, pulse;
  assign in_done = (state_q == DONE);
  assign pulse   = in_done && !flush_i;

  assign miss_ready_o    = (state_q == IDLE) && !flush_i;
  assign busy_o          = (state_q != IDLE);
  assign mem_req_valid_o = (state_q == L1_REQ) || (state_q == L0_REQ);
  assign mem_req_addr_o  = mem_req_valid_o ? addr_q : '0;
  assign refill_valid_o  = pulse && !fault_q;
  assign fault_valid_o   = pulse && fault_q;
  assign fault_access_o  = pulse && fault_q && access_q;
  assign refill_vpn_o    = in_done ? vpn_q : '0;
  assign refill_asid_o   = in_done ? asid_q : '0;
  assign refill_pte_o    = in_done ? pte_q : '0;
  assign refill_super_o  = in_done && super_q;

  resp_in_wait_a: assert property (@(posedge clk_i) disable iff (rst_i)
    mem_resp_valid_i |-> (state_q == L1_WAIT || state_q == L0_WAIT));

endmodule
`default_nettype wire

// File: tb/tb_itlb_ptw.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_itlb_ptw: randomized walks against a behavioural Sv32 walk model. rev 1.0
// ------------------------------------------------------------------------
module tb_itlb_ptw;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic [31:0] satp_i = '0;
  logic        miss_valid_i = 1'b0;
  logic        miss_ready_o;
  logic [31:0] miss_vaddr_i = '0;
  logic [8:0]  miss_asid_i = '0;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b0;
  logic [33:0] mem_req_addr_o;
  logic        mem_resp_valid_i = 1'b0;
  logic [31:0] mem_resp_data_i = '0;
  logic        mem_resp_err_i = 1'b0;
  logic        refill_valid_o;
  logic [19:0] refill_vpn_o;
  logic [8:0]  refill_asid_o;
  logic [31:0] refill_pte_o;
  logic        refill_super_o;
  logic        fault_valid_o;
  logic        fault_access_o;
  logic        busy_o;

  itlb_ptw #(.VADDR_WD(32), .PADDR_WD(34), .MXLEN(32), .ASID_WD(9)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .satp_i(satp_i),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
    .miss_vaddr_i(miss_vaddr_i), .miss_asid_i(miss_asid_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_data_i(mem_resp_data_i), .mem_resp_err_i(mem_resp_err_i),
    .refill_valid_o(refill_valid_o), .refill_vpn_o(refill_vpn_o),
    .refill_asid_o(refill_asid_o), .refill_pte_o(refill_pte_o),
    .refill_super_o(refill_super_o), .fault_valid_o(fault_valid_o),
    .fault_access_o(fault_access_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Expected outcome of the current walk (0 none, 1 refill, 2 fault)
  logic [33:0] exp_addr[$];
  int          exp_kind;
  logic [19:0] exp_vpn;
  logic [8:0]  exp_asid;
  logic [31:0] exp_pte;
  logic        exp_super, exp_access;

  // Memory-side knobs
  logic [31:0] rsp_pte[2];
  logic        rsp_err[2];
  int          fmode = 0;
  bit          rand_ready = 1'b0, zero_wait = 1'b0, hold_l0 = 1'b0, idle_flush = 1'b0;
  int          stall_cnt = 0;
  int          acc_cnt = 0;
  int          cyc = 0;

  int          pulses = 0;
  int          last_pulse_cyc = 0;
  logic [31:0] last_pte;
  logic [19:0] last_vpn;
  logic        last_super, last_access;

  function automatic void model(input logic [31:0] satp, input logic [31:0] va,
                                input logic [8:0] asid, input int fm,
                                input logic [31:0] p1, input logic e1,
                                input logic [31:0] p0, input logic e0);
    logic [31:0] pte;
    logic        err;
    exp_addr.delete();
    exp_vpn = va[31:12]; exp_asid = asid;
    exp_kind = 0; exp_super = 0; exp_access = 0; exp_pte = '0;
    if (!satp[31]) begin
      if (fm != 2) begin
        exp_kind = 1;
        exp_pte  = {2'b00, va[31:12], 10'h0CB};
      end
      return;
    end
    exp_addr.push_back(34'(satp[21:0]) * 34'd4096 + 34'(va[31:22]) * 34'd4);
    if (fm != 0) return;
    for (int lvl = 1; lvl >= 0; lvl--) begin
      pte = (lvl == 1) ? p1 : p0;
      err = (lvl == 1) ? e1 : e0;
      if (err) begin exp_kind = 2; exp_access = 1; return; end
      if (!pte[0] || (!pte[1] && pte[2])) begin exp_kind = 2; return; end
      if (!pte[1] && !pte[3]) begin
        if (lvl == 0) begin exp_kind = 2; return; end
        exp_addr.push_back(34'(pte[31:10]) * 34'd4096 + 34'(va[21:12]) * 34'd4);
      end else begin
        if ((lvl == 1 && pte[19:10] != 0) || !pte[3] || !pte[6]) begin
          exp_kind = 2; return;
        end
        exp_kind = 1; exp_pte = pte; exp_super = (lvl == 1);
        return;
      end
    end
  endfunction

  // Memory responder and flush generator
  initial begin
    bit acc, macc, pend;
    int cnt;
    logic [31:0] rdata;
    logic rerr;
    pend = 0; cnt = 0; rdata = '0; rerr = 0;
    forever begin
      @(posedge clk_i);
      cyc++;
      acc  = mem_req_valid_o && mem_req_ready_i && !rst_i;
      macc = miss_valid_i && miss_ready_o && !rst_i;
      if (rst_i) pend = 0;
      if (macc) acc_cnt = 0;
      if (acc) acc_cnt++;
      #1;
      mem_resp_valid_i = 1'b0;
      mem_resp_err_i   = 1'b0;
      mem_resp_data_i  = $urandom;
      flush_i = idle_flush || (fmode == 2 && macc) || (fmode == 1 && acc && acc_cnt == 1);
      if (acc && !(hold_l0 && acc_cnt == 2)) begin
        pend  = 1;
        rdata = rsp_pte[(acc_cnt >= 2) ? 1 : 0];
        rerr  = rsp_err[(acc_cnt >= 2) ? 1 : 0];
        cnt   = zero_wait ? 0 : $urandom_range(0, 2);
        if (fmode == 1 && cnt == 0) cnt = 1;
      end
      if (pend) begin
        if (cnt == 0) begin
          mem_resp_valid_i = 1'b1;
          mem_resp_data_i  = rdata;
          mem_resp_err_i   = rerr;
          pend = 0;
        end else cnt--;
      end
      if (stall_cnt > 0) begin
        mem_req_ready_i = 1'b0;
        stall_cnt--;
      end else begin
        mem_req_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Per-cycle compare against the model
  logic        prev_hold = 1'b0;
  logic [33:0] prev_addr = '0;
  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_hold <= 1'b0;
    end else begin
      chk("ready_rule", miss_ready_o, !busy_o && !flush_i);
      if (refill_valid_o && fault_valid_o) chk("pulse_exclusive", 1, 0);
      if (mem_req_valid_o) begin
        if (prev_hold) chk("req_stable", mem_req_addr_o, prev_addr);
        if (exp_addr.size() == 0) chk("unexpected_req", mem_req_addr_o, 0);
        else begin
          chk("req_addr", mem_req_addr_o, exp_addr[0]);
          if (mem_req_ready_i) void'(exp_addr.pop_front());
        end
      end else if (prev_hold) begin
        chk("req_withdrawn", 0, 1);
      end
      prev_hold <= mem_req_valid_o && !mem_req_ready_i;
      prev_addr <= mem_req_addr_o;
      if (refill_valid_o || fault_valid_o) begin
        pulses++;
        last_pulse_cyc = cyc;
        last_pte = refill_pte_o; last_vpn = refill_vpn_o;
        last_super = refill_super_o; last_access = fault_access_o;
        chk("pulse_kind", fault_valid_o ? 2 : 1, exp_kind);
        chk("vpn", refill_vpn_o, exp_vpn);
        chk("asid", refill_asid_o, exp_asid);
        if (refill_valid_o) begin
          chk("pte", refill_pte_o, exp_pte);
          chk("super", refill_super_o, exp_super);
        end else begin
          chk("access", fault_access_o, exp_access);
        end
      end
    end
  end

  int t_acc;

  task automatic run_walk(input logic [31:0] satp, input logic [31:0] va, input logic [8:0] asid,
                          input logic [31:0] p1, input logic e1,
                          input logic [31:0] p0, input logic e0, input int fm);
    bit ok;
    int pb;
    rsp_pte[0] = p1; rsp_err[0] = e1;
    rsp_pte[1] = p0; rsp_err[1] = e0;
    fmode = fm;
    model(satp, va, asid, fm, p1, e1, p0, e0);
    satp_i = satp; miss_vaddr_i = va; miss_asid_i = asid; miss_valid_i = 1'b1;
    pb = pulses;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_i);
      if (miss_ready_o) begin ok = 1; break; end
    end
    #1;
    miss_valid_i = 1'b0;
    miss_vaddr_i = $urandom;
    t_acc = cyc - 1;
    if (!ok) chk("accept_timeout", 0, 1);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (!busy_o) begin ok = 1; break; end
    end
    if (!ok) chk("walk_timeout", 0, 1);
    chk("walk_pulses", pulses - pb, (exp_kind != 0) ? 1 : 0);
    chk("reqs_left", exp_addr.size(), 0);
    chk("idle_ready", miss_ready_o, 1);
    fmode = 0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, miss_ready_o, 1);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_reqv"}, mem_req_valid_o, 0);
    chk({tag, "_addr"}, mem_req_addr_o, 0);
    chk({tag, "_refill"}, refill_valid_o, 0);
    chk({tag, "_fault"}, fault_valid_o, 0);
    chk({tag, "_outs"}, {refill_vpn_o, refill_asid_o, refill_pte_o, refill_super_o, fault_access_o}, 0);
  endtask

  function automatic logic [31:0] gen_pte(input bit lvl1);
    logic [31:0] p;
    p = $urandom;
    case ($urandom_range(0, 4))
      0, 1: p[3:0] = 4'b0001;
      2: begin p[0] = 1; p[1] = 1; p[3] = 1; p[6] = 1; if (lvl1) p[19:10] = '0; end
      3: p[0] = 1;
      default: ;
    endcase
    return p;
  endfunction

  initial begin
    logic [31:0] satp, va;
    bit ok;
    int pb;
    rsp_pte[0] = '0; rsp_pte[1] = '0; rsp_err[0] = 0; rsp_err[1] = 0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_reset_outputs("reset");
    @(posedge clk_i); #1;

    // Two-level hit, zero-wait memory: model pinned and latency checked
    zero_wait = 1;
    model(32'h8000_0100, 32'h0040_3123, 9'd5, 0, 32'h0008_0001, 0, 32'h048D_144B, 0);
    chk("model_l1_addr", exp_addr[0], 34'h10_0004);
    chk("model_l0_addr", exp_addr[1], 34'h20_000C);
    chk("model_pte", exp_pte, 32'h048D_144B);
    run_walk(32'h8000_0100, 32'h0040_3123, 9'd5, 32'h0008_0001, 0, 32'h048D_144B, 0, 0);
    chk("latency", last_pulse_cyc - t_acc, 5);
    chk("hit_pte", last_pte, 32'h048D_144B);
    chk("hit_vpn", last_vpn, 20'h00403);
    chk("hit_super", last_super, 0);
    zero_wait = 0;

    run_walk(32'h8000_0100, 32'h0040_3123, 9'd5, 32'h0040_004B, 0, 0, 0, 0);
    chk("super_flag", last_super, 1);
    chk("super_reqs", acc_cnt, 1);
    run_walk(32'h8000_0100, 32'h0040_3123, 9'd5, 32'h0000_0C4B, 0, 0, 0, 0);
    chk("misalign_access", last_access, 0);
    run_walk(32'h8000_0100, 32'h0040_3123, 9'd5, 32'h0008_0001, 0, 32'h048D_1447, 0, 0);
    run_walk(32'h8000_0100, 32'h0040_3123, 9'd5, 32'h0008_0000, 0, 0, 0, 0);
    run_walk(32'h8000_0100, 32'h0040_3123, 9'd5, 32'h0008_0001, 1, 0, 0, 0);
    chk("err_access", last_access, 1);

    stall_cnt = 7;
    run_walk(32'h8000_0100, 32'h0040_3123, 9'd5, 32'h0008_0001, 0, 32'h048D_144B, 0, 0);
    chk("stall_accepts", acc_cnt, 2);

    run_walk(32'h8000_0100, 32'h0040_3123, 9'd5, 32'h0008_0001, 0, 32'h048D_144B, 0, 1);
    chk("flush_accepts", acc_cnt, 1);

    run_walk(32'h0000_0000, 32'h1234_5678, 9'd7, 0, 0, 0, 0, 0);
    chk("bare_pte", last_pte, 32'h048D_14CB);
    chk("bare_reqs", acc_cnt, 0);
    run_walk(32'h0000_0000, 32'h1234_5678, 9'd7, 0, 0, 0, 0, 2);

    // Flush while idle blocks acceptance
    model(32'h0000_0000, 32'h1234_5678, 9'd7, 2, 0, 0, 0, 0);
    @(negedge clk_i) idle_flush = 1;
    @(posedge clk_i); #1 miss_valid_i = 1'b1;
    @(negedge clk_i);
    chk("idle_flush_ready", miss_ready_o, 0);
    idle_flush = 0;
    @(posedge clk_i); #1 miss_valid_i = 1'b0;
    @(negedge clk_i);
    chk("idle_flush_busy", busy_o, 0);
    @(posedge clk_i); #1;

    // Reset while waiting for the level-0 response
    hold_l0 = 1;
    rsp_pte[0] = 32'h0008_0001; rsp_err[0] = 0;
    model(32'h8000_0100, 32'h0040_3123, 9'd5, 0, 32'h0008_0001, 0, 32'h048D_144B, 0);
    satp_i = 32'h8000_0100; miss_vaddr_i = 32'h0040_3123; miss_asid_i = 9'd5; miss_valid_i = 1'b1;
    @(posedge clk_i); #1 miss_valid_i = 1'b0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_i); #1;
      if (acc_cnt == 2) begin ok = 1; break; end
    end
    if (!ok) chk("rst_walk_timeout", 0, 1);
    rst_i = 1'b1;
    exp_addr.delete(); exp_kind = 0;
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_reset_outputs("midrst");
    hold_l0 = 0;
    @(posedge clk_i); #1;

    rand_ready = 1;
    for (int n = 0; n < 200; n++) begin
      satp = $urandom;
      satp[31] = ($urandom_range(0, 7) != 0);
      va = $urandom;
      pb = $urandom_range(0, 19);
      run_walk(satp, va, 9'($urandom), gen_pte(1), ($urandom_range(0, 15) == 0),
               gen_pte(0), ($urandom_range(0, 15) == 0), (pb < 2) ? 1 : ((pb < 4) ? 2 : 0));
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
